// File: rtl/perf_monitor.sv
// Performance monitor: cycle, retired-instruction and per-channel event counters with a
// run/halt/timeout FSM and commit-stall watchdog. Define PERF_MONITOR_SAT_EN for saturating counters.
module perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int WDOG_W = 27
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            clear,
    input  logic                            commit,
    input  logic                            commit_is_ctrl,
    input  logic [31:0]                     commit_pc,
    input  logic [31:0]                     commit_target,
    input  logic [NUM_CH-1:0]               event_inc,
    input  logic [WDOG_W-1:0]               wdog_limit,
    input  logic [$clog2(NUM_CH+2)-1:0]     rd_sel,
    output logic [CNT_W-1:0]                rd_data,
    output logic [1:0]                      state,
    output logic                            halted,
    output logic                            timed_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [CNT_W-1:0]              cyc_q, cyc_d;
    logic [CNT_W-1:0]              ins_q, ins_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  chan_q, chan_d;
    logic [WDOG_W-1:0]             wdog_q, wdog_d;
    logic [WDOG_W-1:0]             limit_q, limit_d;
    logic [CNT_W-1:0]              rd_data_q, rd_data_d;
    logic                          selfLoop;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_MONITOR_SAT_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    assign selfLoop = commit && commit_is_ctrl && (commit_pc == commit_target);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        chan_d  = chan_q;
        wdog_d  = wdog_q;
        limit_d = limit_q;
        if (clear) begin
            state_d = IDLE;
            cyc_d   = '0;
            ins_d   = '0;
            chan_d  = '0;
            wdog_d  = '0;
            limit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        wdog_d  = wdog_limit;
                        limit_d = wdog_limit;
                    end
                end
                RUN: begin
                    cyc_d = bump(cyc_q);
                    if (commit) begin
                        ins_d = bump(ins_q);
                    end
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (event_inc[k]) begin
                            chan_d[k] = bump(chan_q[k]);
                        end
                    end
                    if (commit) begin
                        wdog_d = limit_q;
                    end else if (wdog_q != '0) begin
                        wdog_d = wdog_q - WDOG_W'(1);
                    end
                    // A halting commit also reloads the watchdog, so it always beats a timeout.
                    if (selfLoop) begin
                        state_d = HALTED;
                    end else if (!commit && (wdog_q == '0)) begin
                        state_d = TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read port registers the post-edge counter value so a held rd_sel tracks the live count.
    always_comb begin
        rd_data_d = '0;
        if (32'(rd_sel) == 0) begin
            rd_data_d = cyc_d;
        end else if (32'(rd_sel) == 1) begin
            rd_data_d = ins_d;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (32'(rd_sel) == k + 2) begin
                    rd_data_d = chan_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            ins_q     <= '0;
            chan_q    <= '0;
            wdog_q    <= '0;
            limit_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            chan_q    <= chan_d;
            wdog_q    <= wdog_d;
            limit_q   <= limit_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign state     = state_q;
    assign halted    = (state_q == HALTED);
    assign timed_out = (state_q == TIMEOUT);

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_perf_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int WDOG_W = 8;
    localparam int SEL_W  = 3;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                clear = 1'b0;
    logic                commit = 1'b0;
    logic                commitIsCtrl = 1'b0;
    logic [31:0]         commitPc = 32'h0;
    logic [31:0]         commitTarget = 32'h4;
    logic [NUM_CH-1:0]   eventInc = '0;
    logic [WDOG_W-1:0]   wdogLimit = '0;
    logic [SEL_W-1:0]    rdSel = '0;
    logic [CNT_W-1:0]    rdData;
    logic [1:0]          state;
    logic                halted;
    logic                timedOut;

    int total = 0;
    int bad = 0;

    int mState, mCyc, mIns, mLimit, mStreak;
    int mCh [NUM_CH];

    typedef struct {
        bit        start;
        bit        clear;
        bit        commit;
        bit        ctrl;
        bit        eq;
        bit [3:0]  ev;
        int        sel;
        int        expState;
        int        expRd;
    } vec_t;

    vec_t vecs [20];

    perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .clear          (clear),
        .commit         (commit),
        .commit_is_ctrl (commitIsCtrl),
        .commit_pc      (commitPc),
        .commit_target  (commitTarget),
        .event_inc      (eventInc),
        .wdog_limit     (wdogLimit),
        .rd_sel         (rdSel),
        .rd_data        (rdData),
        .state          (state),
        .halted         (halted),
        .timed_out      (timedOut)
    );

    always #5 clk = ~clk;

    function automatic int bumpM(input int v);
`ifdef PERF_MONITOR_SAT_EN
        return (v >= MAXV) ? MAXV : v + 1;
`else
        return (v + 1) % (MAXV + 1);
`endif
    endfunction

    function automatic vec_t mk(input bit s, input bit c, input bit cm, input bit ctl, input bit eq,
                                input bit [3:0] ev, input int sel, input int es, input int er);
        vec_t v;
        v.start = s; v.clear = c; v.commit = cm; v.ctrl = ctl; v.eq = eq;
        v.ev = ev; v.sel = sel; v.expState = es; v.expRd = er;
        return v;
    endfunction

    task automatic modelReset();
        mState = 0; mCyc = 0; mIns = 0; mLimit = 0; mStreak = 0;
        for (int k = 0; k < NUM_CH; k++) mCh[k] = 0;
    endtask

    // Watchdog modelled as a streak of commit-free RUN cycles: expiry when the streak exceeds the limit.
    task automatic modelStep();
        if (clear) begin
            modelReset();
        end else if (mState == 0) begin
            if (start) begin
                mState = 1;
                mLimit = int'(wdogLimit);
                mStreak = 0;
            end
        end else if (mState == 1) begin
            mCyc = bumpM(mCyc);
            if (commit) mIns = bumpM(mIns);
            for (int k = 0; k < NUM_CH; k++) if (eventInc[k]) mCh[k] = bumpM(mCh[k]);
            if (commit && commitIsCtrl && commitPc == commitTarget) begin
                mState = 2;
            end else if (commit) begin
                mStreak = 0;
            end else begin
                mStreak++;
                if (mStreak > mLimit) mState = 3;
            end
        end
    endtask

    function automatic int modelRead(input int sel);
        if (sel == 0) return mCyc;
        if (sel == 1) return mIns;
        if (sel >= 2 && sel < NUM_CH + 2) return mCh[sel-2];
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit c, input bit cm, input bit ctl, input bit eq,
                                 input bit [3:0] ev, input int sel, input logic [31:0] pc);
        start = s;
        clear = c;
        commit = cm;
        commitIsCtrl = ctl;
        commitPc = pc;
        commitTarget = eq ? pc : pc + 32'd4;
        eventInc = ev;
        rdSel = SEL_W'(sel);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 32'h60);
        rst = 1'b1;
        modelReset();
        #3;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_rd", int'(rdData), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Directed vector table: a run of commits, a non-halting branch, a halt, frozen counts, then clear.
        vecs[0] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) vecs[i] = mk(0, 0, 1, 0, 0, 4'h1, 1, 1, i);
        vecs[11] = mk(0, 0, 1, 1, 0, 4'h0, 1, 1, 11);
        vecs[12] = mk(1, 0, 0, 0, 0, 4'h0, 0, 1, 12);
        vecs[13] = mk(0, 0, 1, 1, 1, 4'h0, 1, 2, 12);
        vecs[14] = mk(1, 0, 1, 0, 0, 4'hF, 1, 2, 12);
        vecs[15] = mk(0, 0, 0, 0, 0, 4'h0, 0, 2, 13);
        vecs[16] = mk(0, 0, 0, 0, 0, 4'hF, 2, 2, 10);
        vecs[17] = mk(0, 0, 0, 0, 0, 4'h0, 7, 2, 0);
        vecs[18] = mk(1, 1, 1, 0, 0, 4'hF, 1, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 4'h0, 2, 0, 0);

        doReset();
        wdogLimit = 8'd20;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].start, vecs[i].clear, vecs[i].commit, vecs[i].ctrl, vecs[i].eq,
                          vecs[i].ev, vecs[i].sel, 32'h60);
            tick();
            checkOutput($sformatf("vec%0d_state", i), int'(state), vecs[i].expState);
            checkOutput($sformatf("vec%0d_rd", i), int'(rdData), vecs[i].expRd);
            checkOutput($sformatf("vec%0d_halted", i), int'(halted), (vecs[i].expState == 2) ? 1 : 0);
        end

        // Watchdog limit 5 with no commits: timeout on the sixth RUN cycle, then frozen.
        doReset();
        wdogLimit = 8'd5;
        applyStimulus(1, 0, 0, 0, 0, 4'h0, 0, 32'h60);
        tick();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 32'h60);
            tick();
            checkOutput($sformatf("wdog_state_%0d", i), int'(state), (i < 6) ? 1 : 3);
            checkOutput($sformatf("wdog_cyc_%0d", i), int'(rdData), i);
        end
        checkOutput("wdog_timed_out", int'(timedOut), 1);
        checkOutput("wdog_halted", int'(halted), 0);
        applyStimulus(1, 0, 1, 0, 0, 4'hF, 0, 32'h60);
        tick();
        checkOutput("timeout_hold_state", int'(state), 3);
        checkOutput("timeout_hold_cyc", int'(rdData), 6);

        // Halting commit in the cycle the watchdog would expire resolves to HALTED.
        doReset();
        wdogLimit = 8'd5;
        applyStimulus(1, 0, 0, 0, 0, 4'h0, 0, 32'h60);
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 32'h60);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 1, 4'h0, 1, 32'h60);
        tick();
        checkOutput("race_state", int'(state), 2);
        checkOutput("race_halted", int'(halted), 1);
        checkOutput("race_ins", int'(rdData), 1);

        // Zero limit: first commit-free RUN cycle times out.
        doReset();
        wdogLimit = 8'd0;
        applyStimulus(1, 0, 0, 0, 0, 4'h0, 0, 32'h60);
        tick();
        checkOutput("zero_limit_run", int'(state), 1);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 32'h60);
        tick();
        checkOutput("zero_limit_timeout", int'(state), 3);

        // 300 event cycles on channel 2 exercise 8-bit wrap or saturation.
        doReset();
        wdogLimit = 8'd5;
        applyStimulus(1, 0, 0, 0, 0, 4'h0, 4, 32'h60);
        tick();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 4'b0100, 4, 32'h60);
            tick();
        end
`ifdef PERF_MONITOR_SAT_EN
        checkOutput("ch2_300", int'(rdData), 255);
`else
        checkOutput("ch2_300", int'(rdData), 44);
`endif
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 2, 32'h60);
        tick();
        checkOutput("ch0_idle", int'(rdData), 0);

        // Asynchronous reset between edges mid-RUN.
        doReset();
        wdogLimit = 8'd10;
        applyStimulus(1, 0, 0, 0, 0, 4'h0, 1, 32'h60);
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 4'h0, 1, 32'h60);
            tick();
        end
        checkOutput("pre_rst_ins", int'(rdData), 5);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_state", int'(state), 0);
        checkOutput("async_rst_rd", int'(rdData), 0);
        checkOutput("async_rst_halted", int'(halted), 0);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 4'hF, 1, 32'h60);
        tick();
        checkOutput("post_rst_state", int'(state), 0);
        checkOutput("post_rst_rd", int'(rdData), 0);

        // Randomized traffic against the behavioural model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            int sel;
            bit ctl;
            if (mState == 0) wdogLimit = WDOG_W'($urandom_range(0, 6));
            sel = int'($urandom_range(0, 7));
            ctl = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 1) == 1, ctl, $urandom_range(0, 7) == 0,
                          4'($urandom), sel, $urandom);
            tick();
            checkOutput("rand_state", int'(state), mState);
            checkOutput("rand_rd", int'(rdData), modelRead(sel));
            checkOutput("rand_flags", int'({halted, timedOut}), (mState == 2) ? 2 : (mState == 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
